// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, optional two-entry skid
// buffer, flush, and a control field that is held at zero whenever the slot is empty.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              accept;
    logic              emit;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign count     = cnt_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            localparam logic [1:0] EMPTY = 2'd0;
            localparam logic [1:0] ONE   = 2'd1;
            localparam logic [1:0] FULL  = 2'd2;

            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Decoded from the count register only, so out_ready never reaches in_ready.
            assign in_ready = (cnt_q != FULL);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_q     <= EMPTY;
                    main_data <= '0;
                    main_ctrl <= '0;
                    skid_data <= '0;
                    skid_ctrl <= '0;
                end else if (flush) begin
                    cnt_q     <= EMPTY;
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                end else begin
                    case (cnt_q)
                        EMPTY: begin
                            if (accept) begin
                                main_data <= in_data;
                                main_ctrl <= in_ctrl;
                                cnt_q     <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept && emit) begin
                                main_data <= in_data;
                                main_ctrl <= in_ctrl;
                            end else if (accept) begin
                                skid_data <= in_data;
                                skid_ctrl <= in_ctrl;
                                cnt_q     <= FULL;
                            end else if (emit) begin
                                main_ctrl <= '0;
                                cnt_q     <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (emit) begin
                                main_data <= skid_data;
                                main_ctrl <= skid_ctrl;
                                skid_ctrl <= '0;
                                cnt_q     <= ONE;
                            end
                        end
                        default: begin
                            main_ctrl <= '0;
                            skid_ctrl <= '0;
                            cnt_q     <= EMPTY;
                        end
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready = ~out_valid | out_ready;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_q     <= 2'd0;
                    main_data <= '0;
                    main_ctrl <= '0;
                end else if (flush) begin
                    cnt_q     <= 2'd0;
                    main_ctrl <= '0;
                end else if (accept) begin
                    main_data <= in_data;
                    main_ctrl <= in_ctrl;
                    cnt_q     <= 2'd1;
                end else if (emit) begin
                    main_ctrl <= '0;
                    cnt_q     <= 2'd0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives a SKID=1 and a SKID=0 instance side by side and
// checks both against queue-based models of a bounded FIFO with flush and reset.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        iv1, ir1, ov1, or1, iv0, ir0, ov0, or0;
    logic [63:0] id1, od1, id0, od0;
    logic [7:0]  ic1, oc1, ic0, oc0;
    logic [1:0]  cnt1, cnt0;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_ctrl(ic1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1), .count(cnt1));

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_ctrl(ic0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ctrl(oc0), .count(cnt0));

    // Models: q*_ hold the entries each stage should be holding, head first.
    logic [63:0] q1d[$], q0d[$], src1_d[$], src0_d[$], got1[$], got0[$];
    logic [7:0]  q1c[$], q0c[$], src1_c[$], src0_c[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic present();
        iv1 = (src1_d.size() != 0);
        iv0 = (src0_d.size() != 0);
        id1 = {$urandom, $urandom}; ic1 = 8'hFF;
        id0 = {$urandom, $urandom}; ic0 = 8'hFF;
        if (iv1) begin id1 = src1_d[0]; ic1 = src1_c[0]; end
        if (iv0) begin id0 = src0_d[0]; ic0 = src0_c[0]; end
    endtask

    // Logs emits, crosses one rising edge updating the models, returns at the falling edge.
    task automatic advance();
        bit a1, a0, e1, e0, m1, m0;
        if (ov1 && or1) got1.push_back(od1);
        if (ov0 && or0) got0.push_back(od0);
        a1 = iv1 && ir1;
        a0 = iv0 && ir0;
        @(posedge clk);
        e1 = (q1d.size() > 0) && or1;
        m1 = iv1 && (q1d.size() < 2);
        e0 = (q0d.size() > 0) && or0;
        m0 = iv0 && ((q0d.size() == 0) || or0);
        if (!rst || flush) begin
            q1d.delete(); q1c.delete(); q0d.delete(); q0c.delete();
        end else begin
            if (e1) begin void'(q1d.pop_front()); void'(q1c.pop_front()); end
            if (m1) begin q1d.push_back(id1); q1c.push_back(ic1); end
            if (e0) begin void'(q0d.pop_front()); void'(q0c.pop_front()); end
            if (m0) begin q0d.push_back(id0); q0c.push_back(ic0); end
            if (a1 && src1_d.size() > 0) begin void'(src1_d.pop_front()); void'(src1_c.pop_front()); end
            if (a0 && src0_d.size() > 0) begin void'(src0_d.pop_front()); void'(src0_c.pop_front()); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        iv1 = 1'b1; iv0 = 1'b1; ic1 = 8'hFF; ic0 = 8'hFF;
        id1 = 64'h1234; id0 = 64'h1234; or1 = 1'b1; or0 = 1'b1;
        @(negedge clk);
        advance();
        advance();
        #1;
        n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_ov1: got %b expected 0", ov1); end
        n_checks++; if (oc1 !== 8'h00) begin n_fail++; $display("FAIL reset_oc1: got %h expected 00", oc1); end
        n_checks++; if (od1 !== 64'h0) begin n_fail++; $display("FAIL reset_od1: got %h expected 0", od1); end
        n_checks++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d expected 0", cnt1); end
        n_checks++; if (ov0 !== 1'b0 || oc0 !== 8'h00 || od0 !== 64'h0 || cnt0 !== 2'd0) begin
            n_fail++; $display("FAIL reset_dut0: got v=%b c=%h d=%h n=%0d expected all 0", ov0, oc0, od0, cnt0);
        end
        rst = 1'b1; iv1 = 1'b0; iv0 = 1'b0;
        advance();
        #1;
        n_checks++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL reset_ir1: got %b expected 1", ir1); end
        n_checks++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL reset_ir0: got %b expected 1", ir0); end
    endtask

    task automatic test_streaming();
        logic [7:0] sc[1:10];
        for (int k = 1; k <= 10; k++) begin
            sc[k] = 8'($urandom);
            src1_d.push_back(64'(k)); src1_c.push_back(sc[k]);
            src0_d.push_back(64'(k)); src0_c.push_back(sc[k]);
        end
        or1 = 1'b1; or0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            present();
            #1;
            if (i >= 1 && i <= 10) begin
                n_checks++; if (ov1 !== 1'b1 || od1 !== 64'(i)) begin
                    n_fail++; $display("FAIL stream_out1[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, ov1, od1, i);
                end
                n_checks++; if (oc1 !== sc[i] || cnt1 !== 2'd1) begin
                    n_fail++; $display("FAIL stream_ctl1[%0d]: got c=%h n=%0d expected c=%h n=1", i, oc1, cnt1, sc[i]);
                end
                n_checks++; if (ov0 !== 1'b1 || od0 !== 64'(i) || oc0 !== sc[i]) begin
                    n_fail++; $display("FAIL stream_out0[%0d]: got v=%b d=%0d c=%h expected v=1 d=%0d c=%h", i, ov0, od0, oc0, i, sc[i]);
                end
            end else begin
                n_checks++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin
                    n_fail++; $display("FAIL stream_idle[%0d]: got v1=%b v0=%b expected 0", i, ov1, ov0);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        got1.delete(); got0.delete();
        for (int k = 1; k <= 4; k++) begin
            src1_d.push_back(64'(k)); src1_c.push_back(8'(8'h10 + k));
            src0_d.push_back(64'(k)); src0_c.push_back(8'(8'h10 + k));
        end
        for (int c = 0; c < 13; c++) begin
            present();
            or1 = !(c >= 1 && c <= 3);
            or0 = or1;
            #1;
            if (c == 1) begin
                n_checks++; if (ir1 !== 1'b1 || od1 !== 64'd1) begin
                    n_fail++; $display("FAIL bp_absorb1: got ir=%b d=%0d expected ir=1 d=1", ir1, od1);
                end
                n_checks++; if (ir0 !== 1'b0) begin n_fail++; $display("FAIL bp_ir0_same_cycle: got %b expected 0", ir0); end
            end
            if (c == 2 || c == 3) begin
                n_checks++; if (cnt1 !== 2'd2 || ir1 !== 1'b0) begin
                    n_fail++; $display("FAIL bp_full1[%0d]: got n=%0d ir=%b expected n=2 ir=0", c, cnt1, ir1);
                end
                n_checks++; if (ir0 !== 1'b0) begin n_fail++; $display("FAIL bp_ir0[%0d]: got %b expected 0", c, ir0); end
            end
            if (c == 4) begin
                n_checks++; if (ir1 !== 1'b0) begin n_fail++; $display("FAIL bp_ir1_release: got %b expected 0", ir1); end
            end
            if (c == 5) begin
                n_checks++; if (ir1 !== 1'b1 || od1 !== 64'd2 || cnt1 !== 2'd1) begin
                    n_fail++; $display("FAIL bp_full_to_one: got ir=%b d=%0d n=%0d expected ir=1 d=2 n=1", ir1, od1, cnt1);
                end
            end
            n_checks++; if (cnt0 > 2'd1) begin n_fail++; $display("FAIL bp_cnt0[%0d]: got %0d expected <=1", c, cnt0); end
            advance();
        end
        n_checks++; if (got1.size() != 4 || got0.size() != 4) begin
            n_fail++; $display("FAIL bp_count_out: got %0d/%0d expected 4/4", got1.size(), got0.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (got1[k] !== 64'(k + 1) || got0[k] !== 64'(k + 1)) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %0d/%0d expected %0d", k, got1[k], got0[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_flush_full();
        or1 = 1'b0; or0 = 1'b0;
        iv1 = 1'b1; iv0 = 1'b1; ic1 = 8'h21; ic0 = 8'h21;
        id1 = 64'd50; id0 = 64'd50;
        advance();
        id1 = 64'd51; id0 = 64'd51;
        #1;
        n_checks++; if (cnt1 !== 2'd1) begin n_fail++; $display("FAIL flush_fill: got %0d expected 1", cnt1); end
        advance();
        flush = 1'b1; id1 = 64'd99; id0 = 64'd99;
        #1;
        n_checks++; if (cnt1 !== 2'd2 || oc1 !== 8'h21) begin
            n_fail++; $display("FAIL flush_pre: got n=%0d c=%h expected n=2 c=21", cnt1, oc1);
        end
        advance();
        flush = 1'b0; iv1 = 1'b0; iv0 = 1'b0; or1 = 1'b1; or0 = 1'b1;
        #1;
        n_checks++; if (cnt1 !== 2'd0 || ov1 !== 1'b0 || oc1 !== 8'h00) begin
            n_fail++; $display("FAIL flush_post1: got n=%0d v=%b c=%h expected 0/0/00", cnt1, ov1, oc1);
        end
        n_checks++; if (cnt0 !== 2'd0 || ov0 !== 1'b0 || oc0 !== 8'h00) begin
            n_fail++; $display("FAIL flush_post0: got n=%0d v=%b c=%h expected 0/0/00", cnt0, ov0, oc0);
        end
        for (int i = 0; i < 4; i++) begin
            advance();
            #1;
            n_checks++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin
                n_fail++; $display("FAIL flush_no99[%0d]: got v1=%b v0=%b expected 0", i, ov1, ov0);
            end
        end
    endtask

    task automatic test_bubble();
        for (int i = 0; i < 5; i++) begin
            iv1 = 1'b0; iv0 = 1'b0; ic1 = 8'hFF; ic0 = 8'hFF;
            or1 = 1'($urandom); or0 = 1'($urandom);
            #1;
            n_checks++; if (ov1 !== 1'b0 || oc1 !== 8'h00) begin
                n_fail++; $display("FAIL bubble1[%0d]: got v=%b c=%h expected 0/00", i, ov1, oc1);
            end
            n_checks++; if (ov0 !== 1'b0 || oc0 !== 8'h00) begin
                n_fail++; $display("FAIL bubble0[%0d]: got v=%b c=%h expected 0/00", i, ov0, oc0);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 63) != 0);
            flush = ($urandom_range(0, 15) == 0);
            iv1 = 1'($urandom); iv0 = 1'($urandom);
            id1 = {$urandom, $urandom}; id0 = {$urandom, $urandom};
            ic1 = 8'($urandom); ic0 = 8'($urandom);
            or1 = ($urandom_range(0, 3) != 0); or0 = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (cnt1 !== 2'(q1d.size()) || ov1 !== (q1d.size() > 0) || ir1 !== (q1d.size() < 2)) begin
                n_fail++; $display("FAIL rand_state1[%0d]: got n=%0d v=%b r=%b expected n=%0d", i, cnt1, ov1, ir1, q1d.size());
            end
            n_checks++; if (cnt0 !== 2'(q0d.size()) || ov0 !== (q0d.size() > 0) || ir0 !== ((q0d.size() == 0) || or0)) begin
                n_fail++; $display("FAIL rand_state0[%0d]: got n=%0d v=%b r=%b expected n=%0d", i, cnt0, ov0, ir0, q0d.size());
            end
            if (q1d.size() > 0) begin
                n_checks++; if (od1 !== q1d[0] || oc1 !== q1c[0]) begin
                    n_fail++; $display("FAIL rand_head1[%0d]: got d=%h c=%h expected d=%h c=%h", i, od1, oc1, q1d[0], q1c[0]);
                end
            end else begin
                n_checks++; if (oc1 !== 8'h00) begin n_fail++; $display("FAIL rand_zero1[%0d]: got %h expected 00", i, oc1); end
            end
            if (q0d.size() > 0) begin
                n_checks++; if (od0 !== q0d[0] || oc0 !== q0c[0]) begin
                    n_fail++; $display("FAIL rand_head0[%0d]: got d=%h c=%h expected d=%h c=%h", i, od0, oc0, q0d[0], q0c[0]);
                end
            end else begin
                n_checks++; if (oc0 !== 8'h00) begin n_fail++; $display("FAIL rand_zero0[%0d]: got %h expected 00", i, oc0); end
            end
            advance();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_bubble();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, fully registered pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, flush, and control-field zeroing on bubbles. It generalises the fixed per-field ID/EX register into one reusable stage for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries. Each instance carries an opaque data payload and a separate control field. The control field is guaranteed to be zero whenever the stage holds no valid instruction, so downstream write enables never fire on a bubble.

## Interface
Parameters:
- DATA_W, 64: width of the payload (pc, inst, operands, …); not qualified by valid.
- CTRL_W, 8: width of the side-effect control field (rd_w_en, csr_w_en, load, store, mul/div valid, ebreak …); forced to 0 when not valid.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discard all held entries (branch redirect or upstream stall-kill).
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream consumes the entry this cycle (e.g. exu_idle & next-stage ready).
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control field; 0 when out_valid = 0.
- count  out  2  number of held entries, 0..2 (0..1 when SKID = 0).

## Operation
- Handshake rules:
  - accept = in_valid & in_ready.
  - emit = out_valid & out_ready.
  - Entries leave in arrival order.
- Storage:
  - Main register (head) drives out_*.
  - Skid register exists only when SKID = 1.
- States (SKID = 1), encoded by count:
  - EMPTY (0):
    - accept → ONE; main loads the input.
  - ONE (1):
    - accept & emit → ONE; main loads the input.
    - accept only → FULL; skid loads the input.
    - emit only → EMPTY.
    - neither → hold.
  - FULL (2):
    - in_ready = 0.
    - emit → ONE; main loads skid.
    - otherwise hold.
- in_ready (SKID = 1) = (count != 2). It is a pure register output with no combinational path from out_ready.
- SKID = 0:
  - in_ready = ~out_valid | out_ready.
  - Main loads on accept.
  - Main goes empty on emit without accept.
- Control zeroing:
  - Whenever a register is marked invalid, its ctrl bits are written 0.
  - out_ctrl = 0 whenever out_valid = 0, in every state and after flush/reset.
  - out_data is undefined-but-stable when invalid: it holds its last value and is not cleared.
- Flush:
  - Priority: reset > flush > normal operation.
  - Next cycle: count = 0, out_valid = 0, out_ctrl = 0.
  - An input offered in the flush cycle is discarded, even though in_ready may be 1 that cycle.
  - An emit in the flush cycle still counts downstream; the entry is not replayed.
- Reset (rst = 0 at an edge):
  - count = 0, out_valid = 0, out_ctrl = 0, out_data = 0.
  - in_ready = 1 from the first cycle after reset release.
  - Reset mid-operation drops all entries identically to flush.

## Timing
- Latency is 1 cycle from accept to out_valid in the EMPTY, or ONE-with-emit, case.
- Full throughput: 1 entry per cycle sustained while out_ready = 1.
- With SKID = 1, the stall-to-backpressure delay is 1 cycle:
  - When out_ready drops, one further input is absorbed into skid.
  - in_ready falls on the next edge.
- With SKID = 1, FULL → ONE on emit. in_ready returns to 1 the cycle after that edge; the previously skidded entry appears on out_* the same edge.
- No output of this block is combinationally derived from in_valid. The only combinational path is out_ready → in_ready, and only when SKID = 0.
- Each entry's data and ctrl are captured in the same edge; they never split across entries.

## Test plan
- Reset:
  - Stimulus: hold rst = 0 for 2 cycles with in_valid = 1, in_ctrl = 8'hFF.
  - Required: out_valid = 0, out_ctrl = 0, out_data = 0, count = 0; in_ready = 1 in the first cycle after release.
- Streaming (SKID = 1):
  - Stimulus: 10 back-to-back entries with data 1..10 and out_ready = 1 throughout.
  - Required: out_data = 1..10 on consecutive cycles starting 1 cycle after the first accept; count stays 1; no bubbles.
- Backpressure:
  - Stimulus: stream data 1..4 and drop out_ready at the cycle entry 1 is presented; hold it low for 3 cycles, then raise it.
  - Required:
    - Entry 2 is absorbed and count = 2.
    - in_ready = 0 for the stall duration.
    - Output order is 1, 2, 3, 4, with none lost or duplicated.
- Flush in FULL:
  - Stimulus: from count = 2 with ctrl = 8'h21, assert flush together with in_valid = 1, data = 99.
  - Required: next cycle count = 0, out_valid = 0, out_ctrl = 0; entry 99 never appears.
- Bubble zeroing:
  - Stimulus: in_valid = 0 with in_ctrl = 8'hFF for 5 cycles after the last emit.
  - Required: out_ctrl = 0 and out_valid = 0 on every one of those cycles.
- SKID = 0:
  - Stimulus: the same stall as the Backpressure scenario.
  - Required: in_ready = 0 in the same cycle out_ready = 0 with out_valid = 1; count never exceeds 1; order is preserved.
